// File: rtl/i_mem_fill.sv
// Instruction memory with a 4-word cache-line fill engine (fixed latency 6).
// Optional one-entry pending request buffer: define I_MEM_FILL_PENDING_EN.

package i_mem_fill_pkg;

    typedef struct packed {
        logic [31:0] fill_requested_address;
        logic        fill_requested_address_valid;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic [127:0] filled_cl;
        logic [27:0]  fill_tag_address;
        logic         filled_cl_valid;
    } t_i_mem2cache_rsp;

endpackage

module i_mem_fill
    import i_mem_fill_pkg::*;
#(
    parameter int unsigned I_MEM_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  t_cache2i_mem_req cache2i_mem_req,
    output t_i_mem2cache_rsp i_mem2cache_rsp,
    input  logic             imem_wr_en,
    input  logic [31:0]      imem_wr_addr,
    input  logic [31:0]      imem_wr_data
);

    localparam int unsigned AW = $clog2(I_MEM_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StResp
    } state_e;

    state_e       state_q;
    logic [1:0]   beat_q;
    logic [27:0]  tag_q;
    logic [95:0]  line_q;
    logic [127:0] filled_cl_q;
    logic [27:0]  rsp_tag_q;
    logic         rsp_valid_q;
    logic         rd_valid_q;
    logic [1:0]   rd_off_q;
    logic [31:0]  rdata_q;

`ifdef I_MEM_FILL_PENDING_EN
    logic         pend_valid_q;
    logic [27:0]  pend_tag_q;
`endif

    logic [31:0]  mem [I_MEM_WORDS];

    logic         req_valid;
    logic [27:0]  req_tag;
    logic         rd_en;
    logic [27:0]  rd_tag;
    logic [1:0]   rd_off;
    logic [29:0]  rd_word;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic         unused_bits;

    assign req_valid = cache2i_mem_req.fill_requested_address_valid;
    assign req_tag   = cache2i_mem_req.fill_requested_address[31:4];
    assign rd_word   = {rd_tag, rd_off};
    assign rd_idx    = rd_word[AW-1:0];
    assign wr_idx    = imem_wr_addr[AW+1:2];

    // Upper address bits wrap; the line offset nibble is irrelevant to a fill.
    assign unused_bits = ^{imem_wr_addr, rd_word, cache2i_mem_req.fill_requested_address[3:0]};

    // Read port address selection.
    always_comb begin
        rd_en  = 1'b0;
        rd_tag = tag_q;
        rd_off = beat_q;
        if (state_q == StRead) begin
            rd_en = 1'b1;
        end
`ifdef I_MEM_FILL_PENDING_EN
        // A chained fill issues its offset-0 read during RESP.
        if (state_q == StResp && pend_valid_q) begin
            rd_en  = 1'b1;
            rd_tag = pend_tag_q;
            rd_off = 2'd0;
        end
`endif
    end

    // Storage is never reset; read-during-write returns the old word.
    always_ff @(posedge clk) begin
        if (imem_wr_en) begin
            mem[wr_idx] <= imem_wr_data;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= 2'd0;
            tag_q        <= '0;
            line_q       <= '0;
            filled_cl_q  <= '0;
            rsp_tag_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_off_q     <= 2'd0;
`ifdef I_MEM_FILL_PENDING_EN
            pend_valid_q <= 1'b0;
            pend_tag_q   <= '0;
`endif
        end else begin
            rd_valid_q  <= rd_en;
            rd_off_q    <= rd_off;
            rsp_valid_q <= 1'b0;

            // Word 3 bypasses line_q and is merged straight into the response.
            if (rd_valid_q) begin
                case (rd_off_q)
                    2'd0:    line_q[31:0]  <= rdata_q;
                    2'd1:    line_q[63:32] <= rdata_q;
                    2'd2:    line_q[95:64] <= rdata_q;
                    default: ;
                endcase
            end

            unique case (state_q)
                StIdle: begin
`ifdef I_MEM_FILL_PENDING_EN
                    if (pend_valid_q) begin
                        tag_q        <= pend_tag_q;
                        pend_valid_q <= 1'b0;
                        beat_q       <= 2'd0;
                        state_q      <= StRead;
                    end else
`endif
                    if (req_valid) begin
                        tag_q   <= req_tag;
                        beat_q  <= 2'd0;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    filled_cl_q <= {rdata_q, line_q};
                    rsp_tag_q   <= tag_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
`ifdef I_MEM_FILL_PENDING_EN
                    if (pend_valid_q) begin
                        tag_q        <= pend_tag_q;
                        pend_valid_q <= 1'b0;
                        beat_q       <= 2'd1;
                        state_q      <= StRead;
                    end else
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

`ifdef I_MEM_FILL_PENDING_EN
            if (state_q != StIdle && req_valid && req_tag != tag_q && !pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_tag_q   <= req_tag;
            end
`endif
        end
    end

    always_comb begin
        i_mem2cache_rsp.filled_cl        = filled_cl_q;
        i_mem2cache_rsp.fill_tag_address = rsp_tag_q;
        i_mem2cache_rsp.filled_cl_valid  = rsp_valid_q;
    end

endmodule
